// File: rtl/mem_arb_pkg.sv
// Shared types for the core/debug memory arbiter.
// Holds the FSM state, owner encoding and burst-length default.
package mem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCK_D = 1'b1
   } state_e;

   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int unsigned LOCK_MAX_DEF = 16;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin grant (core vs debug) with its pointer register.
// The pointer only flips on a contested grant; the top may force it to core.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_c_i,
   input  logic req_d_i,
   input  logic mask_c_i,
   input  logic ptr_to_c_i,
   output logic gnt_c_o,
   output logic gnt_d_o
);

   owner_e ptr_q, ptr_d;
   logic   req_c;

   always_comb begin
      req_c   = req_c_i & ~mask_c_i;
      gnt_c_o = 1'b0;
      gnt_d_o = 1'b0;
      ptr_d   = ptr_q;
      if (req_c && req_d_i) begin
         if (ptr_q == OWN_C) begin
            gnt_c_o = 1'b1;
            ptr_d   = OWN_D;
         end else begin
            gnt_d_o = 1'b1;
            ptr_d   = OWN_C;
         end
      end else begin
         gnt_c_o = req_c;
         gnt_d_o = req_d_i;
      end
      if (ptr_to_c_i) begin
         ptr_d = OWN_C;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= OWN_C;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core LSU and a debug/loader master.
// Debug may lock the port for up to LOCK_MAX grants; reads return next cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_c_req,
   input  logic [31:0] i_c_addr,
   input  logic        i_c_wren,
   input  logic [31:0] i_c_wdata,
   input  logic [2:0]  i_c_funct3,
   output logic        o_c_gnt,
   output logic        o_c_rvalid,
   output logic [31:0] o_c_rdata,
   input  logic        i_d_req,
   input  logic [31:0] i_d_addr,
   input  logic        i_d_wren,
   input  logic [31:0] i_d_wdata,
   input  logic [2:0]  i_d_funct3,
   input  logic        i_d_lock,
   output logic        o_d_gnt,
   output logic        o_d_rvalid,
   output logic [31:0] o_d_rdata,
   output logic        o_m_req,
   output logic [31:0] o_m_addr,
   output logic        o_m_wren,
   output logic [31:0] o_m_wdata,
   output logic [2:0]  o_m_funct3,
   input  logic [31:0] i_m_rdata
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
   localparam bit CAN_LOCK = (LOCK_MAX > 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rd_pend_q, rd_pend_d;
   owner_e          rd_own_q, rd_own_d;
   logic            gnt_c, gnt_d;
   logic            ptr_to_c;
   logic            lock_mode;

   assign lock_mode = (state_q == LOCK_D);

   // Requests are gated by reset so nothing is granted while held in reset.
   arb_rr2 u_rr (
      .clk_i      (i_clk),
      .rst_ni     (i_reset),
      .req_c_i    (i_c_req & i_reset),
      .req_d_i    (i_d_req & i_reset),
      .mask_c_i   (lock_mode),
      .ptr_to_c_i (ptr_to_c),
      .gnt_c_o    (gnt_c),
      .gnt_d_o    (gnt_d)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_to_c = 1'b0;
      unique case (state_q)
         ARB: begin
            if (gnt_d && i_d_lock && CAN_LOCK) begin
               state_d = LOCK_D;
               cnt_d   = CW'(1);
            end
         end
         LOCK_D: begin
            if (gnt_d) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (!i_d_lock || (gnt_d && (cnt_q + CW'(1)) == LMAX)) begin
               state_d  = ARB;
               cnt_d    = '0;
               ptr_to_c = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      o_c_gnt    = gnt_c;
      o_d_gnt    = gnt_d;
      o_m_req    = gnt_c | gnt_d;
      o_m_addr   = '0;
      o_m_wren   = 1'b0;
      o_m_wdata  = '0;
      o_m_funct3 = '0;
      if (gnt_c) begin
         o_m_addr   = i_c_addr;
         o_m_wren   = i_c_wren;
         o_m_wdata  = i_c_wdata;
         o_m_funct3 = i_c_funct3;
      end else if (gnt_d) begin
         o_m_addr   = i_d_addr;
         o_m_wren   = i_d_wren;
         o_m_wdata  = i_d_wdata;
         o_m_funct3 = i_d_funct3;
      end
      rd_pend_d = o_m_req & ~o_m_wren;
      rd_own_d  = gnt_d ? OWN_D : OWN_C;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ARB;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_own_q  <= OWN_C;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         rd_own_q  <= rd_own_d;
      end
   end

   assign o_c_rvalid = rd_pend_q & (rd_own_q == OWN_C);
   assign o_d_rvalid = rd_pend_q & (rd_own_q == OWN_D);
   assign o_c_rdata  = o_c_rvalid ? i_m_rdata : 32'h0;
   assign o_d_rdata  = o_d_rvalid ? i_m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, routing, round-robin,
// debug lock bursts and reset during a pending read.
module tb_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_c_req, i_c_wren;
   logic [31:0] i_c_addr, i_c_wdata;
   logic [2:0]  i_c_funct3;
   logic        o_c_gnt, o_c_rvalid;
   logic [31:0] o_c_rdata;
   logic        i_d_req, i_d_wren, i_d_lock;
   logic [31:0] i_d_addr, i_d_wdata;
   logic [2:0]  i_d_funct3;
   logic        o_d_gnt, o_d_rvalid;
   logic [31:0] o_d_rdata;
   logic        o_m_req, o_m_wren;
   logic [31:0] o_m_addr, o_m_wdata;
   logic [2:0]  o_m_funct3;
   logic [31:0] i_m_rdata = 32'h0;

   int cmp_n = 0;
   int fail_n = 0;

   mem_arbiter #(.LOCK_MAX(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_c_req(i_c_req), .i_c_addr(i_c_addr), .i_c_wren(i_c_wren),
      .i_c_wdata(i_c_wdata), .i_c_funct3(i_c_funct3),
      .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata),
      .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_wren(i_d_wren),
      .i_d_wdata(i_d_wdata), .i_d_funct3(i_d_funct3), .i_d_lock(i_d_lock),
      .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
      .o_m_req(o_m_req), .o_m_addr(o_m_addr), .o_m_wren(o_m_wren),
      .o_m_wdata(o_m_wdata), .o_m_funct3(o_m_funct3),
      .i_m_rdata(i_m_rdata)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
   endfunction

   // Memory returns read data one cycle after an accepted read.
   always @(posedge i_clk)
      i_m_rdata <= (o_m_req && !o_m_wren) ? mem_f(o_m_addr) : 32'h0;

   task automatic set_in(input logic cr, input logic [31:0] ca,
                         input logic cw, input logic dr,
                         input logic [31:0] da, input logic dw,
                         input logic dl);
      @(negedge i_clk);
      i_c_req = cr; i_c_addr = ca; i_c_wren = cw;
      i_d_req = dr; i_d_addr = da; i_d_wren = dw; i_d_lock = dl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_reset = 1'b0;
      i_c_req = 0; i_d_req = 0; i_d_lock = 0;
      @(negedge i_clk);
      i_reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_reset = 1'b0;
      i_c_req = 1; i_d_req = 1; i_c_addr = 32'h44; i_d_addr = 32'h88;
      i_c_wren = 0; i_d_wren = 0; i_d_lock = 1;
      #1;
      cmp_n++;
      if ({o_c_gnt, o_d_gnt, o_m_req} !== 3'b000) begin
         fail_n++;
         $display("FAIL rst_gnt got %b want 000", {o_c_gnt, o_d_gnt, o_m_req});
      end
      cmp_n++;
      if (o_m_addr !== 32'h0) begin
         fail_n++;
         $display("FAIL rst_maddr got %h want 0", o_m_addr);
      end
      @(negedge i_clk); #1;
      cmp_n++;
      if ({o_c_rvalid, o_d_rvalid} !== 2'b00) begin
         fail_n++;
         $display("FAIL rst_rvalid got %b want 00", {o_c_rvalid, o_d_rvalid});
      end
      i_c_req = 0; i_d_req = 0; i_d_lock = 0;
      @(negedge i_clk);
      i_reset = 1'b1;
   endtask

   task automatic test_core_load();
      i_c_funct3 = 3'b010; i_d_funct3 = 3'b100;
      set_in(1, 32'h10, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if ({o_c_gnt, o_d_gnt, o_m_req, o_m_wren} !== 4'b1010) begin
         fail_n++;
         $display("FAIL cl_gnt got %b want 1010",
                  {o_c_gnt, o_d_gnt, o_m_req, o_m_wren});
      end
      cmp_n++;
      if (o_m_addr !== 32'h10 || o_m_funct3 !== 3'b010) begin
         fail_n++;
         $display("FAIL cl_maddr got %h/%b want 10/010", o_m_addr, o_m_funct3);
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_c_rvalid !== 1'b1 || o_c_rdata !== 32'hDEADBEEF) begin
         fail_n++;
         $display("FAIL cl_rdata got %b/%h want 1/deadbeef", o_c_rvalid, o_c_rdata);
      end
      cmp_n++;
      if (o_d_rvalid !== 1'b0 || o_d_rdata !== 32'h0) begin
         fail_n++;
         $display("FAIL cl_drv got %b/%h want 0/0", o_d_rvalid, o_d_rdata);
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_c_rvalid !== 1'b0 || o_c_rdata !== 32'h0) begin
         fail_n++;
         $display("FAIL cl_rdone got %b/%h want 0/0", o_c_rvalid, o_c_rdata);
      end
   endtask

   task automatic test_debug_store_fields();
      i_d_wdata = 32'hCAFE_1234;
      set_in(0, 32'h0, 0, 1, 32'h80, 1, 0);
      cmp_n++;
      if (o_d_gnt !== 1'b1 || o_m_wren !== 1'b1 || o_m_wdata !== 32'hCAFE_1234
          || o_m_funct3 !== 3'b100 || o_m_addr !== 32'h80) begin
         fail_n++;
         $display("FAIL ds_fields got g%b w%b %h %b %h want 1 1 cafe1234 100 80",
                  o_d_gnt, o_m_wren, o_m_wdata, o_m_funct3, o_m_addr);
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if ({o_c_rvalid, o_d_rvalid} !== 2'b00) begin
         fail_n++;
         $display("FAIL ds_norv got %b want 00", {o_c_rvalid, o_d_rvalid});
      end
   endtask

   task automatic test_alternate();
      logic ec;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1, 32'h100, 0, 1, 32'h200, 0, 0);
         ec = (k % 2 == 0);
         cmp_n++;
         if (o_c_gnt !== ec || o_d_gnt !== !ec) begin
            fail_n++;
            $display("FAIL alt_gnt k=%0d got %b%b want %b%b",
                     k, o_c_gnt, o_d_gnt, ec, !ec);
         end
         cmp_n++;
         if (o_m_addr !== (ec ? 32'h100 : 32'h200)) begin
            fail_n++;
            $display("FAIL alt_addr k=%0d got %h", k, o_m_addr);
         end
         if (k > 0) begin
            cmp_n++;
            if (o_c_rvalid !== !ec || o_d_rvalid !== ec) begin
               fail_n++;
               $display("FAIL alt_rv k=%0d got %b%b want %b%b",
                        k, o_c_rvalid, o_d_rvalid, !ec, ec);
            end
            cmp_n++;
            if (ec ? (o_d_rdata !== (32'h200 ^ 32'h5A5A_0000))
                   : (o_c_rdata !== (32'h100 ^ 32'h5A5A_0000))) begin
               fail_n++;
               $display("FAIL alt_rd k=%0d got c%h d%h", k, o_c_rdata, o_d_rdata);
            end
         end
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_d_rvalid !== 1'b1 || o_c_rvalid !== 1'b0
          || o_d_rdata !== (32'h200 ^ 32'h5A5A_0000)) begin
         fail_n++;
         $display("FAIL alt_last got %b%b %h", o_c_rvalid, o_d_rvalid, o_d_rdata);
      end
   endtask

   task automatic test_lock_burst();
      logic ec;
      int   dcnt;
      dcnt = 0;
      do_reset();
      for (int k = 0; k < 18; k++) begin
         set_in(1, 32'h100, 0, 1, 32'h300, 0, 1);
         ec = (k == 0 || k == 17);
         if (o_d_gnt === 1'b1) dcnt++;
         cmp_n++;
         if (o_c_gnt !== ec || o_d_gnt !== !ec) begin
            fail_n++;
            $display("FAIL lock_gnt k=%0d got %b%b want %b%b",
                     k, o_c_gnt, o_d_gnt, ec, !ec);
         end
         if (k > 0) begin
            cmp_n++;
            if (o_c_rvalid !== (k == 1) || o_d_rvalid !== (k >= 2)) begin
               fail_n++;
               $display("FAIL lock_rv k=%0d got %b%b", k, o_c_rvalid, o_d_rvalid);
            end
         end
      end
      cmp_n++;
      if (dcnt !== 16) begin
         fail_n++;
         $display("FAIL lock_count got %0d want 16", dcnt);
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_c_rvalid !== 1'b1 || o_c_rdata !== (32'h100 ^ 32'h5A5A_0000)) begin
         fail_n++;
         $display("FAIL lock_crv got %b/%h", o_c_rvalid, o_c_rdata);
      end
   endtask

   task automatic test_lock_store();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) set_in(0, 32'h40, 0, 1, 32'h500, 1, 1);
         else       set_in(1, 32'h40, 0, 1, 32'h500, 1, 0);
         cmp_n++;
         if (o_c_gnt !== (k == 4) || o_d_gnt !== (k != 4)) begin
            fail_n++;
            $display("FAIL ls_gnt k=%0d got %b%b want %b%b",
                     k, o_c_gnt, o_d_gnt, (k == 4), (k != 4));
         end
         cmp_n++;
         if ({o_c_rvalid, o_d_rvalid} !== 2'b00) begin
            fail_n++;
            $display("FAIL ls_norv k=%0d got %b%b", k, o_c_rvalid, o_d_rvalid);
         end
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_c_rvalid !== 1'b1 || o_d_rvalid !== 1'b0
          || o_c_rdata !== (32'h40 ^ 32'h5A5A_0000)) begin
         fail_n++;
         $display("FAIL ls_crv got %b%b %h", o_c_rvalid, o_d_rvalid, o_c_rdata);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_in(1, 32'h10, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if (o_c_gnt !== 1'b1) begin
         fail_n++;
         $display("FAIL rm_gnt got %b want 1", o_c_gnt);
      end
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      i_c_req = 0;
      #1;
      cmp_n++;
      if (o_c_rvalid !== 1'b0 || o_c_rdata !== 32'h0) begin
         fail_n++;
         $display("FAIL rm_rv got %b/%h want 0/0", o_c_rvalid, o_c_rdata);
      end
      @(negedge i_clk);
      i_reset = 1'b1;
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cmp_n++;
      if ({o_c_rvalid, o_d_rvalid} !== 2'b00) begin
         fail_n++;
         $display("FAIL rm_after got %b want 00", {o_c_rvalid, o_d_rvalid});
      end
      set_in(1, 32'h20, 0, 1, 32'h30, 0, 1);
      cmp_n++;
      if (o_c_gnt !== 1'b1 || o_d_gnt !== 1'b0) begin
         fail_n++;
         $display("FAIL rm_ptr got %b%b want 10", o_c_gnt, o_d_gnt);
      end
      set_in(0, 32'h0, 0, 0, 32'h0, 0, 0);
   endtask

   initial begin
      i_reset = 1'b0;
      i_c_req = 0; i_c_addr = 0; i_c_wren = 0; i_c_wdata = 0; i_c_funct3 = 0;
      i_d_req = 0; i_d_addr = 0; i_d_wren = 0; i_d_wdata = 0; i_d_funct3 = 0;
      i_d_lock = 0;
      test_reset();
      test_core_load();
      test_debug_store_fields();
      test_alternate();
      test_lock_burst();
      test_lock_store();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

endmodule
